// File: rtl/tx_sample_fifo.sv
// ---------------------------------------------------------------------------
// tx_sample_fifo
//
// Elastic sample buffer between the DSP output and the I2S transmitter.
// Everything runs on the I2S bit clock. The buffer primes to half-full
// before it releases samples. After that it pops one sample per I2S frame,
// on the falling edge of word-select. Underflow and overflow are kept as
// sticky flags that drive the board error LED.
//
// Parameters
//   WIDTH          sample width in bits
//   DEPTH          FIFO depth in samples (power of two, >= 4)
//
// Ports
//   sclk_i         I2S bit clock; all logic on the rising edge
//   rst_i          synchronous, active-high reset
//   wrData_i       sample from the DSP
//   wrValid_i      one-cycle write strobe from the DSP
//   ws_i           I2S word-select; a falling edge marks frame start
//   clrErr_i       clears the sticky error flags
//   sample_o       sample presented to the transmitter, held for a frame
//   sampleValid_o  one-cycle pulse when sample_o loads a new entry
//   level_o        current occupancy, 0..DEPTH
//   underflow_o    sticky: pop attempted while empty in RUN
//   overflow_o     sticky: write attempted while full
//   errorLED_o     underflow_o | overflow_o
// ---------------------------------------------------------------------------
module tx_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     sclk_i,
  input  logic                     rst_i,
  input  logic [WIDTH-1:0]         wrData_i,
  input  logic                     wrValid_i,
  input  logic                     ws_i,
  input  logic                     clrErr_i,
  output logic [WIDTH-1:0]         sample_o,
  output logic                     sampleValid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     underflow_o,
  output logic                     overflow_o,
  output logic                     errorLED_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] PRIME_COUNT = CNT_W'(DEPTH / 2);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ws_prev;

  logic pop_req;
  logic empty;
  logic full;
  logic pop_ok;
  logic pop_fail;
  logic wr_accept;
  logic wr_drop;

  // Frame start is the falling edge of word-select. ws_prev resets to 0, so
  // a low ws_i in the first cycle after reset does not look like an edge.
  assign pop_req = ws_prev & ~ws_i;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // A full FIFO still accepts a write in a cycle where a pop succeeds,
  // because the pop frees a slot. Both decisions use the pre-cycle count.
  assign wr_accept = wrValid_i & (~full | pop_ok);
  assign wr_drop   = wrValid_i & full & ~pop_ok;

  // Next-state and pop decision. In FILL, frame edges are ignored until the
  // registered count reaches half depth. In RUN, a frame edge on an empty
  // buffer is an underflow, and the buffer goes back to FILL to re-prime.
  always_comb begin
    next_state = state;
    pop_ok     = 1'b0;
    pop_fail   = 1'b0;

    case (state)
      FILL: begin
        if (count >= PRIME_COUNT) begin
          next_state = RUN;
        end
      end

      RUN: begin
        if (pop_req) begin
          if (!empty) begin
            pop_ok = 1'b1;
          end else begin
            pop_fail   = 1'b1;
            next_state = FILL;
          end
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // Sample storage. This array has no reset: after a reset the pointers
  // make its contents unreachable until they are written again.
  always_ff @(posedge sclk_i) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wrData_i;
    end
  end

  // Pointers, occupancy and the word-select history. Simultaneous
  // write and pop leave the count unchanged.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ws_prev <= 1'b0;
    end else begin
      ws_prev <= ws_i;

      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({wr_accept, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmitter-facing sample register. On an underflow it keeps the last
  // value, so the transmitter repeats the previous sample.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      sample_o      <= '0;
      sampleValid_o <= 1'b0;
    end else begin
      sampleValid_o <= pop_ok;
      if (pop_ok) begin
        sample_o <= mem[rd_ptr];
      end
    end
  end

  // Sticky error flags. A set event in the same cycle as clrErr_i wins.
  always_ff @(posedge sclk_i) begin
    if (rst_i) begin
      underflow_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      underflow_o <= pop_fail | (underflow_o & ~clrErr_i);
      overflow_o  <= wr_drop  | (overflow_o  & ~clrErr_i);
    end
  end

  assign level_o    = count;
  assign errorLED_o = underflow_o | overflow_o;

endmodule
